gcm_ghash_ctrl: RTL and testbench
=================================

GCM_GHASH_CTRL -- requirements
Module: gcm_ghash_ctrl

Interface
REQ-001 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have h_load  input  1  pulse; loads hash subkey from h_key.
REQ-004 SHALL have h_key  input  128  hash subkey H.
REQ-005 SHALL have start  input  1  pulse; begins a new GHASH, sampling aad_bits/ct_bits.
REQ-006 SHALL have aad_bits, ct_bits  input  64 each  bit lengths for the final length block.
REQ-007 SHALL have blk_valid, blk_last  input  1 each  data block valid; last data block.
REQ-008 SHALL have blk_data  input  128  data block X (AAD then ciphertext, pre-padded).
REQ-009 SHALL have blk_ready  output  1  block accepted when blk_valid & blk_ready.
REQ-010 SHALL have mul_start  output  1  one-cycle request to the GF(2^128) multiplier.
REQ-011 SHALL have mul_a, mul_b  output  128 each  multiplier operands.
REQ-012 SHALL have mul_done  input  1  multiplier result valid (any latency >= 1 cycle).
REQ-013 SHALL have mul_res  input  128  multiplier product.
REQ-014 SHALL have hash_out  output  128  final GHASH value; hash_valid  output  1  one-cycle pulse.
REQ-015 SHALL have busy  output  1  high in any state except IDLE; blk_cnt  output  32  blocks absorbed this hash.

Function
REQ-016 SHALL implement states IDLE, WAIT_BLK, MUL, LEN, LEN_MUL, DONE.
REQ-017 SHALL load h_reg from h_key on h_load only in IDLE; h_load outside IDLE is ignored.
REQ-018 In IDLE, start SHALL clear Y and blk_cnt, latch {aad_bits, ct_bits} into len_reg, and go to WAIT_BLK; if aad_bits and ct_bits are both 0, it SHALL go directly to LEN.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 blk_ready SHALL be 1 only in WAIT_BLK (combinational from state).
REQ-021 On accept, the block SHALL drive mul_a = Y ^ blk_data and mul_b = h_reg (registered), pulse mul_start for exactly one cycle, increment blk_cnt (modulo 2^32), latch blk_last, and enter MUL.
REQ-022 In MUL, on mul_done, the block SHALL set Y = mul_res and go to LEN if the latched last flag is 1, else to WAIT_BLK.
REQ-023 mul_done in any state other than MUL/LEN_MUL SHALL be ignored; mul_done in the same cycle as mul_start SHALL NOT occur (multiplier min latency 1).
REQ-024 In LEN, the block SHALL drive mul_a = Y ^ len_reg and mul_b = h_reg, pulse mul_start once, and enter LEN_MUL.
REQ-025 In LEN_MUL, on mul_done, the block SHALL register hash_out = mul_res and enter DONE.
REQ-026 DONE SHALL last one cycle with hash_valid = 1, then return to IDLE; hash_out SHALL hold until the next hash_valid.
REQ-027 mul_a/mul_b SHALL remain stable from mul_start until mul_done.
REQ-028 Throughput: one block per (multiplier latency + 2) cycles; no buffering beyond one block.

Reset
REQ-029 reset SHALL force IDLE, clear Y, h_reg, len_reg, blk_cnt and hash_out to 0, and drive blk_ready, mul_start, hash_valid and busy to 0.
REQ-030 reset asserted mid-hash SHALL abort with no hash_valid; a mul_done arriving after reset SHALL be ignored.
REQ-031 reset SHALL take priority over h_load, start and blk_valid in the same cycle.

Verification
REQ-032 h_key=H, start, aad_bits=0, ct_bits=128, one block X1 with blk_last, model multiplier latency 3 -> mul_a=X1 then (X1*H)^{64'h0,64'h80}, hash_valid once, blk_cnt=1.
REQ-033 start with aad_bits=ct_bits=0 -> blk_ready never asserted, single mul_start with mul_a=0, hash_out=0.
REQ-034 Three blocks, blk_valid held high, multiplier latency 1 and 7 -> blk_ready low during MUL, hash_out matches the reference GHASH model.
REQ-035 start and h_load pulsed in WAIT_BLK -> both ignored, len_reg/h_reg unchanged.
REQ-036 reset asserted in MUL, then spurious mul_done -> IDLE, all outputs 0, no hash_valid.
REQ-037 Spurious mul_done in IDLE/WAIT_BLK -> Y unchanged, no state change.

Source files
------------

// File: rtl/gcm_ghash_ctrl.sv
// GHASH sequencer: absorbs pre-padded 128-bit blocks, then the length block, through an external GF(2^128) multiplier.
// Takes one block per (multiplier latency + 2) cycles; blk_ready is high only in WAIT_BLK, so at most one block is in flight.
module gcm_ghash_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         h_load,
  input  logic [127:0] h_key,
  input  logic         start,
  input  logic [63:0]  aad_bits,
  input  logic [63:0]  ct_bits,
  input  logic         blk_valid,
  input  logic         blk_last,
  input  logic [127:0] blk_data,
  output logic         blk_ready,
  output logic         mul_start,
  output logic [127:0] mul_a,
  output logic [127:0] mul_b,
  input  logic         mul_done,
  input  logic [127:0] mul_res,
  output logic [127:0] hash_out,
  output logic         hash_valid,
  output logic         busy,
  output logic [31:0]  blk_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BLK,
    MUL,
    LEN,
    LEN_MUL,
    DONE
  } state_t;

  state_t       state;
  logic [127:0] y_reg;
  logic [127:0] h_reg;
  logic [127:0] len_reg;
  logic         last_reg;

  assign blk_ready = (state == WAIT_BLK);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      y_reg      <= '0;
      h_reg      <= '0;
      len_reg    <= '0;
      last_reg   <= 1'b0;
      blk_cnt    <= '0;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      hash_out   <= '0;
      hash_valid <= 1'b0;
    end else begin
      mul_start  <= 1'b0;
      hash_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (h_load) begin
            h_reg <= h_key;
          end
          if (start) begin
            y_reg   <= '0;
            blk_cnt <= '0;
            len_reg <= {aad_bits, ct_bits};
            // An empty message still hashes the (all-zero) length block.
            state   <= ((aad_bits == 64'd0) && (ct_bits == 64'd0)) ? LEN : WAIT_BLK;
          end
        end
        WAIT_BLK: begin
          if (blk_valid) begin
            mul_a     <= y_reg ^ blk_data;
            mul_b     <= h_reg;
            mul_start <= 1'b1;
            blk_cnt   <= blk_cnt + 32'd1;
            last_reg  <= blk_last;
            state     <= MUL;
          end
        end
        MUL: begin
          if (mul_done) begin
            y_reg <= mul_res;
            state <= last_reg ? LEN : WAIT_BLK;
          end
        end
        LEN: begin
          mul_a     <= y_reg ^ len_reg;
          mul_b     <= h_reg;
          mul_start <= 1'b1;
          state     <= LEN_MUL;
        end
        LEN_MUL: begin
          if (mul_done) begin
            hash_out   <= mul_res;
            hash_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Multiplier handshake properties: single-cycle request, operands held while it works.
  a_mul_pulse: assert property (@(posedge clk) disable iff (reset)
    mul_start |=> !mul_start);

  a_no_early_done: assert property (@(posedge clk) disable iff (reset)
    mul_start |-> !mul_done);

  a_operands_stable: assert property (@(posedge clk) disable iff (reset)
    ((state == MUL || state == LEN_MUL) && !mul_done) |=> ($stable(mul_a) && $stable(mul_b)));

  a_ready_only_waiting: assert property (@(posedge clk) disable iff (reset)
    blk_ready |-> (state == WAIT_BLK));

endmodule

// File: tb/tb_gcm_ghash_ctrl.sv
// Bench for gcm_ghash_ctrl: behavioural multiplier with variable latency plus a GHASH reference model.
module tb_gcm_ghash_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         h_load;
  logic [127:0] h_key;
  logic         start;
  logic [63:0]  aad_bits;
  logic [63:0]  ct_bits;
  logic         blk_valid;
  logic         blk_last;
  logic [127:0] blk_data;
  logic         blk_ready;
  logic         mul_start;
  logic [127:0] mul_a;
  logic [127:0] mul_b;
  logic         mul_done = 1'b0;
  logic [127:0] mul_res = '0;
  logic [127:0] hash_out;
  logic         hash_valid;
  logic         busy;
  logic [31:0]  blk_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gcm_ghash_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .h_load    (h_load),
    .h_key     (h_key),
    .start     (start),
    .aad_bits  (aad_bits),
    .ct_bits   (ct_bits),
    .blk_valid (blk_valid),
    .blk_last  (blk_last),
    .blk_data  (blk_data),
    .blk_ready (blk_ready),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_res   (mul_res),
    .hash_out  (hash_out),
    .hash_valid(hash_valid),
    .busy      (busy),
    .blk_cnt   (blk_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // GF(2^128) product with GCM bit ordering (bit 127 of the vector is x^0).
  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural multiplier and observation monitor, all sampled on the falling edge.
  int           lat = 3;
  logic         inj_req = 1'b0;
  logic         pend = 1'b0;
  logic         stable_chk = 1'b0;
  int           cnt = 0;
  logic [127:0] cap_a = '0;
  logic [127:0] cap_b = '0;
  logic [127:0] a_log[$];
  logic [127:0] b_log[$];
  int           hv_cnt = 0;
  int           rdy_cnt = 0;

  always @(negedge clk) begin
    mul_done = 1'b0;
    if (pend) begin
      if (stable_chk) begin
        check("mul_a_stable", mul_a, cap_a);
        check("mul_b_stable", mul_b, cap_b);
        check("no_restart", mul_start, 1'b0);
        check("rdy_low_in_mul", blk_ready, 1'b0);
      end
      cnt--;
      if (cnt == 0) begin
        mul_done = 1'b1;
        mul_res  = gf_mul(cap_a, cap_b);
        pend     = 1'b0;
      end
    end
    if (inj_req) begin
      mul_done = 1'b1;
      mul_res  = rand128();
    end
    if (mul_start) begin
      pend       = 1'b1;
      cnt        = lat;
      cap_a      = mul_a;
      cap_b      = mul_b;
      stable_chk = 1'b1;
      a_log.push_back(mul_a);
      b_log.push_back(mul_b);
    end
    if (reset) stable_chk = 1'b0;
    if (hash_valid) hv_cnt++;
    if (blk_ready) rdy_cnt++;
  end

  logic [127:0] cur_h = '0;

  task automatic run_hash(input logic [127:0] h, input bit load_h, input logic [63:0] aad,
                          input logic [63:0] ct, input logic [127:0] xs[$], input int l,
                          input bit hold, input bit disturb, input bit spur);
    logic [127:0] y;
    logic [127:0] len;
    logic [127:0] hk;
    logic [127:0] exp_a[$];
    int a0, hv0, rdy0, t;
    lat = l;
    if (load_h) begin
      h_load = 1'b1;
      h_key  = h;
      tick();
      h_load = 1'b0;
      h_key  = '0;
      cur_h  = h;
    end
    hk  = cur_h;
    len = {aad, ct};
    y   = '0;
    foreach (xs[i]) begin
      exp_a.push_back(y ^ xs[i]);
      y = gf_mul(y ^ xs[i], hk);
    end
    exp_a.push_back(y ^ len);
    y = gf_mul(y ^ len, hk);

    a0   = a_log.size();
    hv0  = hv_cnt;
    rdy0 = rdy_cnt;
    start    = 1'b1;
    aad_bits = aad;
    ct_bits  = ct;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("cnt_cleared", blk_cnt, 32'd0);
    if (disturb) begin
      start    = 1'b1;
      aad_bits = ~aad;
      ct_bits  = ct ^ 64'h1234;
      h_load   = 1'b1;
      h_key    = ~hk;
      tick();
      start  = 1'b0;
      h_load = 1'b0;
      h_key  = '0;
    end
    if (spur) begin
      inj_req = 1'b1;
      tick();
      inj_req = 1'b0;
      check("spur_wait_state", blk_ready, 1'b1);
    end

    foreach (xs[i]) begin
      blk_valid = 1'b1;
      blk_data  = xs[i];
      blk_last  = (i == xs.size() - 1);
      t = 0;
      while (!blk_ready && t < 200) begin
        tick();
        t++;
      end
      check("blk_ready_seen", blk_ready, 1'b1);
      tick();
      check("blk_cnt", blk_cnt, i + 1);
      if (!hold || i == xs.size() - 1) begin
        blk_valid = 1'b0;
        blk_last  = 1'b0;
        if (!hold) repeat ($urandom_range(0, 2)) tick();
      end
    end
    blk_valid = 1'b0;

    t = 0;
    while (!hash_valid && t < 500) begin
      tick();
      t++;
    end
    check("hash_valid_seen", hash_valid, 1'b1);
    check("hash_out", hash_out, y);
    check("blk_cnt_final", blk_cnt, xs.size());
    tick();
    check("hash_valid_pulse", hash_valid, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("hash_hold", hash_out, y);
    check("hv_count", hv_cnt - hv0, 1);
    check("n_mul", a_log.size() - a0, exp_a.size());
    foreach (exp_a[k]) begin
      if (a0 + k < a_log.size()) begin
        check("mul_a_seq", a_log[a0+k], exp_a[k]);
        check("mul_b_seq", b_log[a0+k], hk);
      end
    end
    if (xs.size() == 0) check("rdy_never", rdy_cnt - rdy0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] q[$];
    logic [127:0] h;
    logic [127:0] prev_out;
    int hv0;
    int n;
    reset     = 1'b1;
    h_load    = 1'b0;
    h_key     = '0;
    start     = 1'b0;
    aad_bits  = '0;
    ct_bits   = '0;
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    blk_data  = '0;
    repeat (3) tick();
    check("rst_blk_ready", blk_ready, 1'b0);
    check("rst_mul_start", mul_start, 1'b0);
    check("rst_hash_valid", hash_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_blk_cnt", blk_cnt, 32'd0);
    check("rst_hash_out", hash_out, 128'd0);
    check("rst_mul_a", mul_a, 128'd0);
    reset = 1'b0;
    tick();

    // Single block, latency 3, ciphertext length 128.
    h = rand128();
    q.delete();
    q.push_back(rand128());
    run_hash(h, 1'b1, 64'd0, 64'd128, q, 3, 1'b0, 1'b0, 1'b0);

    // Empty message goes straight to the length block.
    q.delete();
    run_hash(h, 1'b0, 64'd0, 64'd0, q, 2, 1'b0, 1'b0, 1'b0);
    check("empty_hash_zero", hash_out, 128'd0);

    // Three blocks with blk_valid held, fastest and slow multiplier.
    q.delete();
    repeat (3) q.push_back(rand128());
    run_hash(rand128(), 1'b1, 64'd128, 64'd256, q, 1, 1'b1, 1'b0, 1'b0);
    run_hash(rand128(), 1'b1, 64'd128, 64'd256, q, 7, 1'b1, 1'b0, 1'b0);

    // start/h_load pulsed mid-hash must not disturb the result.
    q.delete();
    repeat (2) q.push_back(rand128());
    run_hash(rand128(), 1'b1, 64'd200, 64'd56, q, 4, 1'b0, 1'b1, 1'b0);

    // Spurious mul_done in IDLE, then in WAIT_BLK.
    prev_out = hash_out;
    inj_req = 1'b1;
    tick();
    inj_req = 1'b0;
    tick();
    check("spur_idle_busy", busy, 1'b0);
    check("spur_idle_hash", hash_out, prev_out);
    q.delete();
    repeat (2) q.push_back(rand128());
    run_hash(rand128(), 1'b1, 64'd0, 64'd256, q, 2, 1'b0, 1'b0, 1'b1);

    // Reset while the multiplier is busy; its late mul_done must be ignored.
    hv0 = hv_cnt;
    lat = 6;
    start    = 1'b1;
    aad_bits = 64'd0;
    ct_bits  = 64'd128;
    tick();
    start     = 1'b0;
    blk_valid = 1'b1;
    blk_data  = rand128();
    blk_last  = 1'b1;
    tick();
    blk_valid = 1'b0;
    blk_last  = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    cur_h = '0;
    check("abort_busy", busy, 1'b0);
    check("abort_blk_ready", blk_ready, 1'b0);
    check("abort_mul_start", mul_start, 1'b0);
    check("abort_hash_valid", hash_valid, 1'b0);
    check("abort_hash_out", hash_out, 128'd0);
    check("abort_blk_cnt", blk_cnt, 32'd0);
    check("abort_mul_a", mul_a, 128'd0);
    check("abort_mul_b", mul_b, 128'd0);
    check("abort_no_hv", hv_cnt - hv0, 0);

    // Subkey was cleared by reset: a hash without h_load multiplies by zero.
    q.delete();
    q.push_back(rand128());
    run_hash('0, 1'b0, 64'd0, 64'd128, q, 2, 1'b0, 1'b0, 1'b0);

    // Randomized hashes.
    for (int r = 0; r < 6; r++) begin
      q.delete();
      n = $urandom_range(1, 4);
      for (int b = 0; b < n; b++) q.push_back(rand128());
      run_hash(rand128(), ($urandom_range(0, 3) != 0), {32'd0, $urandom}, {32'd0, $urandom | 32'd1},
               q, $urandom_range(1, 8), $urandom_range(0, 1) == 1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
